fetch_seq_ctrl: RTL and testbench

Fetch-stage sequencer that owns the architectural fetch PC and drives the instruction-bus request. Arbitrates the three redirect sources (trap entry/return, CSR-write flush, branch/jalr resolution) into one next-PC, and tracks outstanding requests so that a response fetched from a stale PC is discarded. Holds a fetched instruction until decode accepts it. Sits between the ibus port and the IF/ID pipeline register.

---
 rtl/fetch_seq_ctrl_pkg.sv | 29 ++
 rtl/fetch_seq_ctrl_redirect_prio.sv | 41 ++++
 rtl/fetch_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl_pkg
// Brief    : Shared types and constants for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_seq_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_CSR  = 2'd2,
        RD_TRAP = 2'd3
    } redirect_src_t;

endpackage
`default_nettype wire

// File: rtl/fetch_seq_ctrl_redirect_prio.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl_redirect_prio
// Brief    : Fixed-priority select of the redirect source (trap > csr > br).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl_redirect_prio
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            csr_flush_valid,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    output redirect_src_t   src,
    output logic [XLEN-1:0] tgt,
    output logic            redirect
);

    always_comb begin
        src = RD_NONE;
        tgt = br_pc;
        if (trap_valid) begin
            src = RD_TRAP;
            tgt = trap_pc;
        end else if (csr_flush_valid) begin
            src = RD_CSR;
            tgt = csr_pc;
        end else if (br_valid) begin
            src = RD_BR;
            tgt = br_pc;
        end
    end

    assign redirect = trap_valid | csr_flush_valid | br_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl
// Brief    : Fetch PC owner and ibus requester; drops stale responses.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            ireq_data_ok,
    input  logic [31:0]     ireq_data,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            csr_flush_valid,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    input  logic            id_ready,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            redirect
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;

    redirect_src_t   rd_src;
    logic [XLEN-1:0] rd_tgt;
    logic            rd_any;
    logic            rd_taken;

    fetch_seq_ctrl_redirect_prio #(
        .XLEN (XLEN)
    ) u_redirect_prio (
        .trap_valid      (trap_valid),
        .trap_pc         (trap_pc),
        .csr_flush_valid (csr_flush_valid),
        .csr_pc          (csr_pc),
        .br_valid        (br_valid),
        .br_pc           (br_pc),
        .src             (rd_src),
        .tgt             (rd_tgt),
        .redirect        (rd_any)
    );

    assign rd_taken = (rd_src != RD_NONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // A request cannot be withdrawn, so a redirect without data_ok parks in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (ireq_data_ok) begin
                    state_d = rd_taken ? S_REQ : S_HOLD;
                end else if (rd_taken) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (rd_taken || id_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (ireq_data_ok) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        case (state_q)
            S_IDLE: begin
                if (rd_taken) begin
                    pc_d = rd_tgt;
                end
            end
            S_REQ: begin
                if (ireq_data_ok) begin
                    if (rd_taken) begin
                        pc_d = rd_tgt;
                    end else begin
                        instr_d       = ireq_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end
                end else if (rd_taken) begin
                    pend_pc_d = rd_tgt;
                end
            end
            S_HOLD: begin
                if (rd_taken) begin
                    instr_valid_d = 1'b0;
                    pc_d          = rd_tgt;
                end else if (id_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc_q + XLEN'(4);
                end
            end
            S_DRAIN: begin
                if (rd_taken) begin
                    pend_pc_d = rd_tgt;
                end
                // The response in flight belongs to the abandoned PC
                if (ireq_data_ok) begin
                    pc_d = rd_taken ? rd_tgt : pend_pc_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ireq_valid  = (state_q == S_REQ) || (state_q == S_DRAIN);
        ireq_addr   = pc_q;
        instr_valid = instr_valid_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        redirect    = rd_any;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq_ctrl
// Brief    : Self-checking bench for fetch_seq_ctrl with address/instr queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq_ctrl;

    localparam logic [63:0] C_RESET_PC = 64'h8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_instr_t;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ireq_data_ok;
    logic [31:0] ireq_data;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic        csr_flush_valid;
    logic [63:0] csr_pc;
    logic        br_valid;
    logic [63:0] br_pc;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_addr_q[$];
    exp_instr_t  exp_instr_q[$];
    logic        prev_valid = 1'b0;
    logic        prev_ok    = 1'b0;
    logic [31:0] snap_instr;

    fetch_seq_ctrl #(
        .XLEN     (64),
        .RESET_PC (C_RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ireq_valid      (ireq_valid),
        .ireq_addr       (ireq_addr),
        .ireq_data_ok    (ireq_data_ok),
        .ireq_data       (ireq_data),
        .trap_valid      (trap_valid),
        .trap_pc         (trap_pc),
        .csr_flush_valid (csr_flush_valid),
        .csr_pc          (csr_pc),
        .br_valid        (br_valid),
        .br_pc           (br_pc),
        .id_ready        (id_ready),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect        (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] idata(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_instr(input logic [63:0] pc);
        exp_instr_t e;
        e.pc   = pc;
        e.data = idata(pc);
        exp_instr_q.push_back(e);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!ireq_valid && n < 20) begin
            tick();
            n++;
        end
        if (!ireq_valid) check("req_timeout", 64'(ireq_valid), 64'd1);
    endtask

    // Request is up on entry; data_ok arrives lat cycles later; ends in HOLD
    task automatic fetch(input int lat);
        wait_req();
        repeat (lat) tick();
        ireq_data    = idata(ireq_addr);
        ireq_data_ok = 1'b1;
        tick();
        ireq_data_ok = 1'b0;
    endtask

    // Scoreboard: each new request and each decode handshake pops an expectation
    always @(negedge clk) begin
        if (ireq_valid && (!prev_valid || prev_ok)) begin
            if (exp_addr_q.size() == 0) begin
                check("req_unexpected", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("req_addr", ireq_addr, exp_addr_q.pop_front());
            end
        end
        if (instr_valid && id_ready && !redirect) begin
            if (exp_instr_q.size() == 0) begin
                check("instr_unexpected", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_instr_t e;
                e = exp_instr_q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr_data", 64'(instr), 64'(e.data));
            end
        end
        prev_valid = ireq_valid;
        prev_ok    = ireq_data_ok;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        ireq_data_ok    = 1'b0;
        ireq_data       = '0;
        trap_valid      = 1'b0;
        trap_pc         = '0;
        csr_flush_valid = 1'b0;
        csr_pc          = '0;
        br_valid        = 1'b0;
        br_pc           = '0;
        id_ready        = 1'b1;

        repeat (3) tick();
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_addr", ireq_addr, C_RESET_PC);

        // Sequential fetch, data_ok two cycles after each request
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(C_RESET_PC + 64'(4 * i));
            push_instr(C_RESET_PC + 64'(4 * i));
        end
        exp_addr_q.push_back(64'h8000_000C);
        push_instr(64'h8000_000C);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(2);
            check("seq_instr_valid", 64'(instr_valid), 64'd1);
            check("seq_instr_pc", instr_pc, C_RESET_PC + 64'(4 * i));
            tick();
            check("seq_valid_drop", 64'(instr_valid), 64'd0);
        end

        // Decode stall for five cycles
        id_ready = 1'b0;
        fetch(1);
        snap_instr = instr;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(instr_valid), 64'd1);
            check("stall_ireq", 64'(ireq_valid), 64'd0);
            check("stall_instr", 64'(instr), 64'(snap_instr));
            check("stall_pc", instr_pc, 64'h8000_000C);
            tick();
        end
        exp_addr_q.push_back(64'h8000_0010);
        id_ready = 1'b1;
        tick();
        check("stall_next_addr", ireq_addr, 64'h8000_000C + 64'd4);

        // Branch while a request is outstanding, response three cycles later
        exp_addr_q.push_back(64'h8000_0100);
        br_valid = 1'b1;
        br_pc    = 64'h8000_0100;
        #2;
        check("br_redirect", 64'(redirect), 64'd1);
        tick();
        br_valid = 1'b0;
        check("drain_ireq", 64'(ireq_valid), 64'd1);
        check("drain_addr", ireq_addr, 64'h8000_0010);
        tick();
        tick();
        ireq_data    = idata(ireq_addr);
        ireq_data_ok = 1'b1;
        check("drain_no_instr", 64'(instr_valid), 64'd0);
        tick();
        ireq_data_ok = 1'b0;
        check("drain_discard", 64'(instr_valid), 64'd0);
        check("drain_new_addr", ireq_addr, 64'h8000_0100);

        // All three redirect sources at once while holding an instruction
        push_instr(64'h8000_0100);
        exp_addr_q.push_back(64'h8000_0104);
        exp_addr_q.push_back(64'h8000_0200);
        fetch(0);
        tick();
        fetch(1);
        check("hold_valid", 64'(instr_valid), 64'd1);
        trap_valid      = 1'b1;
        trap_pc         = 64'h8000_0200;
        csr_flush_valid = 1'b1;
        csr_pc          = 64'h8000_0010;
        br_valid        = 1'b1;
        br_pc           = 64'h8000_0300;
        #2;
        check("all_redirect", 64'(redirect), 64'd1);
        tick();
        trap_valid      = 1'b0;
        csr_flush_valid = 1'b0;
        br_valid        = 1'b0;
        check("all_valid_drop", 64'(instr_valid), 64'd0);
        check("all_trap_addr", ireq_addr, 64'h8000_0200);

        // Two redirects during DRAIN; the newest (csr beats br) wins
        exp_addr_q.push_back(64'h0000_0180);
        br_valid = 1'b1;
        br_pc    = 64'h0000_0100;
        tick();
        csr_flush_valid = 1'b1;
        csr_pc          = 64'h0000_0180;
        br_pc           = 64'h0000_0240;
        tick();
        csr_flush_valid = 1'b0;
        br_valid        = 1'b0;
        tick();
        ireq_data_ok = 1'b1;
        tick();
        ireq_data_ok = 1'b0;
        check("drain2_addr", ireq_addr, 64'h0000_0180);

        // Redirect with same-cycle data_ok, then PC wrap at the top
        exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_addr_q.push_back(64'h0);
        push_instr(64'hFFFF_FFFF_FFFF_FFFC);
        ireq_data    = idata(ireq_addr);
        ireq_data_ok = 1'b1;
        br_valid     = 1'b1;
        br_pc        = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        ireq_data_ok = 1'b0;
        br_valid     = 1'b0;
        check("okrd_discard", 64'(instr_valid), 64'd0);
        check("okrd_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(0);
        check("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_addr", ireq_addr, 64'h0);

        // Reset in the middle of DRAIN
        br_valid = 1'b1;
        br_pc    = 64'h0000_0500;
        tick();
        br_valid = 1'b0;
        check("pre_rst_ireq", 64'(ireq_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_ireq", 64'(ireq_valid), 64'd0);
        check("mid_rst_addr", ireq_addr, C_RESET_PC);
        check("mid_rst_ivalid", 64'(instr_valid), 64'd0);
        tick();
        tick();
        exp_addr_q.push_back(C_RESET_PC);
        exp_addr_q.push_back(C_RESET_PC + 64'd4);
        push_instr(C_RESET_PC);
        ireq_data    = 32'hDEAD_BEEF;
        ireq_data_ok = 1'b1;
        reset        = 1'b1;
        tick();
        ireq_data_ok = 1'b0;
        check("restart_addr", ireq_addr, C_RESET_PC);
        check("restart_ivalid", 64'(instr_valid), 64'd0);
        fetch(1);
        check("restart_pc", instr_pc, C_RESET_PC);
        tick();
        tick();

        check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        check("instr_q_empty", 64'(exp_instr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
